// File: rtl/inst_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch_if
// Description : Instruction-fetch stage bus bundle. It carries the pipeline
//               control inputs, the instruction-memory request/acknowledge
//               bus and the IF/ID presentation outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_fetch_if;
   // Pipeline control
   logic        stall_i;
   logic        branch_flag_i;
   logic [31:0] branch_target_i;
   // Instruction-memory bus
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_ack_i;
   logic [31:0] imem_rdata_i;
   // IF/ID presentation
   logic [31:0] if_pc_o;
   logic [31:0] if_inst_o;
   logic        if_valid_o;

   // Fetch-stage side
   modport master (
      input  stall_i, branch_flag_i, branch_target_i, imem_ack_i, imem_rdata_i,
      output imem_req_o, imem_addr_o, if_pc_o, if_inst_o, if_valid_o
   );

   // Environment side: control, memory and IF/ID register
   modport slave (
      output stall_i, branch_flag_i, branch_target_i, imem_ack_i, imem_rdata_i,
      input  imem_req_o, imem_addr_o, if_pc_o, if_inst_o, if_valid_o
   );
endinterface
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : inst_fetch
// Description : Instruction-fetch stage. Owns the PC, issues word reads on a
//               req/ack memory bus with arbitrary wait states, and presents
//               each fetched instruction with its PC and a valid flag.
//               Handles stall (hold outputs, park one fetched word) and
//               branch redirect (including redirect while a request is
//               outstanding, which kills the in-flight response).
// Revision    : 1.0 - initial release
// ============================================================================
module inst_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input wire logic    clk,
   input wire logic    rst,
   inst_fetch_if.master bus
);

   localparam logic [31:0] c_RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

   typedef enum logic [1:0] {
      S_BOOT = 2'd0,
      S_REQ  = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_redirect_pc;
   logic        r_kill;
   logic [31:0] r_held_pc;
   logic [31:0] r_held_inst;
   logic [31:0] r_if_pc;
   logic [31:0] r_if_inst;
   logic        r_if_valid;

   // Branch target forced to a word boundary; pc[1:0] therefore stays 0.
   logic [31:0] w_target;
   logic [31:0] w_pc_inc;

   assign w_target = bus.branch_target_i & 32'hFFFF_FFFC;
   assign w_pc_inc = r_pc + 32'd4;

   // Bus outputs decode directly from registers so a reset drops req at once.
   assign bus.imem_req_o  = (r_state == S_REQ);
   assign bus.imem_addr_o = r_pc;
   assign bus.if_pc_o     = r_if_pc;
   assign bus.if_inst_o   = r_if_inst;
   assign bus.if_valid_o  = r_if_valid;

   // Fetch FSM: PC sequencing, redirect/kill tracking and IF/ID output regs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_BOOT;
         r_pc          <= c_RESET_PC_ALIGNED;
         r_redirect_pc <= 32'd0;
         r_kill        <= 1'b0;
         r_held_pc     <= 32'd0;
         r_held_inst   <= 32'd0;
         r_if_pc       <= 32'd0;
         r_if_inst     <= 32'd0;
         r_if_valid    <= 1'b0;
      end else begin
         case (r_state)
            S_BOOT: begin
               if (bus.branch_flag_i) begin
                  r_pc <= w_target;
                  if (!bus.stall_i) begin
                     r_if_valid <= 1'b0;
                     r_if_inst  <= 32'd0;
                  end
               end
               r_state <= S_REQ;
            end

            S_REQ: begin
               if (bus.imem_ack_i) begin
                  if (bus.branch_flag_i || r_kill) begin
                     // Response belongs to a superseded path: drop it and
                     // restart at the newest redirect address.
                     r_pc   <= bus.branch_flag_i ? w_target : r_redirect_pc;
                     r_kill <= 1'b0;
                     if (!bus.stall_i) begin
                        r_if_valid <= 1'b0;
                        r_if_inst  <= 32'd0;
                     end
                  end else if (!bus.stall_i) begin
                     r_if_pc    <= r_pc;
                     r_if_inst  <= bus.imem_rdata_i;
                     r_if_valid <= 1'b1;
                     r_pc       <= w_pc_inc;
                  end else begin
                     // Downstream is full: park the word until the stall clears.
                     r_held_pc   <= r_pc;
                     r_held_inst <= bus.imem_rdata_i;
                     r_pc        <= w_pc_inc;
                     r_state     <= S_HOLD;
                  end
               end else begin
                  // The address must stay put while the request is open, so
                  // a redirect is remembered and the pending response killed.
                  if (bus.branch_flag_i) begin
                     r_redirect_pc <= w_target;
                     r_kill        <= 1'b1;
                  end
                  if (!bus.stall_i) begin
                     r_if_valid <= 1'b0;
                     r_if_inst  <= 32'd0;
                  end
               end
            end

            S_HOLD: begin
               if (bus.branch_flag_i) begin
                  r_pc    <= w_target;
                  r_state <= S_REQ;
                  if (!bus.stall_i) begin
                     r_if_valid <= 1'b0;
                     r_if_inst  <= 32'd0;
                  end
               end else if (!bus.stall_i) begin
                  r_if_pc    <= r_held_pc;
                  r_if_inst  <= r_held_inst;
                  r_if_valid <= 1'b1;
                  r_state    <= S_REQ;
               end
            end

            default: begin
               r_state <= S_BOOT;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_fetch
// Description : Self-checking bench for inst_fetch: a directed vector table,
//               a mid-request reset sequence and a randomized run compared
//               against a queue-based behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_fetch;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   inst_fetch_if bus ();

   inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_total = 0;
   int n_bad   = 0;

   typedef struct {
      logic        stall;
      logic        br;
      logic [31:0] tgt;
      logic        ack;
      logic [31:0] rdata;
      logic        e_req;
      logic [31:0] e_addr;
      logic [31:0] e_pc;
      logic [31:0] e_inst;
      logic        e_valid;
   } vec_t;

   vec_t vq[$];

   // Behavioural model: fetched-but-unpresented words and pending redirect
   // targets are kept as queues.
   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
   } fw_t;

   bit          m_boot;
   logic [31:0] m_pc;
   logic [31:0] m_redir[$];
   fw_t         m_buf[$];
   logic [31:0] m_opc;
   logic [31:0] m_oinst;
   logic        m_ovalid;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic er, input logic [31:0] ea,
                          input logic [31:0] ep, input logic [31:0] ei, input logic ev);
      chk($sformatf("%s req", tag),   {31'd0, bus.imem_req_o}, {31'd0, er});
      chk($sformatf("%s addr", tag),  bus.imem_addr_o, ea);
      chk($sformatf("%s pc", tag),    bus.if_pc_o, ep);
      chk($sformatf("%s inst", tag),  bus.if_inst_o, ei);
      chk($sformatf("%s valid", tag), {31'd0, bus.if_valid_o}, {31'd0, ev});
   endtask

   task automatic add(input logic s, input logic b, input logic [31:0] t, input logic a,
                      input logic [31:0] d, input logic er, input logic [31:0] ea,
                      input logic [31:0] ep, input logic [31:0] ei, input logic ev);
      vq.push_back('{s, b, t, a, d, er, ea, ep, ei, ev});
   endtask

   task automatic drive(input logic s, input logic b, input logic [31:0] t,
                        input logic a, input logic [31:0] d);
      bus.stall_i         = s;
      bus.branch_flag_i   = b;
      bus.branch_target_i = t;
      bus.imem_ack_i      = a;
      bus.imem_rdata_i    = d;
   endtask

   // Holds reset for two cycles, checks the reset state, releases at a negedge.
   task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1'b1;
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      @(negedge clk);
      @(negedge clk);
      chk_all(tag, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      rst      = 1'b0;
      m_boot   = 1'b1;
      m_pc     = 32'h0;
      m_redir.delete();
      m_buf.delete();
      m_opc    = 32'h0;
      m_oinst  = 32'h0;
      m_ovalid = 1'b0;
   endtask

   task automatic m_bubble();
      m_ovalid = 1'b0;
      m_oinst  = 32'h0;
   endtask

   // One clock of fetch-stage behaviour, from the inputs seen at the edge.
   task automatic model_step(input logic s, input logic b, input logic [31:0] t,
                             input logic a, input logic [31:0] d);
      logic [31:0] ta;
      fw_t         f;
      ta = t & 32'hFFFF_FFFC;
      if (m_boot) begin
         m_boot = 1'b0;
         if (b) begin
            m_pc = ta;
            if (!s) m_bubble();
         end
      end else if (m_buf.size() != 0) begin
         if (b) begin
            m_buf.delete();
            m_pc = ta;
            if (!s) m_bubble();
         end else if (!s) begin
            f        = m_buf.pop_front();
            m_opc    = f.pc;
            m_oinst  = f.inst;
            m_ovalid = 1'b1;
         end
      end else if (a) begin
         if (b || m_redir.size() != 0) begin
            m_pc = b ? ta : m_redir[0];
            m_redir.delete();
            if (!s) m_bubble();
         end else begin
            if (!s) begin
               m_opc    = m_pc;
               m_oinst  = d;
               m_ovalid = 1'b1;
            end else begin
               m_buf.push_back('{m_pc, d});
            end
            m_pc = m_pc + 32'd4;
         end
      end else begin
         if (b) begin
            m_redir.delete();
            m_redir.push_back(ta);
         end
         if (!s) m_bubble();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        s, b, a;
      logic [31:0] t, d;

      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);

      // ---------------- Directed vector table ----------------
      //   stall br  target         ack rdata          req addr           if_pc          if_inst        valid
      add(0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_0000, 32'h0,          32'h0,          0);
      add(0, 0, 32'h0,          1, 32'hA000_0000,  1, 32'h0000_0004, 32'h0,          32'hA000_0000,  1);
      add(0, 0, 32'h0,          1, 32'hA000_0001,  1, 32'h0000_0008, 32'h4,          32'hA000_0001,  1);
      add(0, 0, 32'h0,          1, 32'hA000_0002,  1, 32'h0000_000C, 32'h8,          32'hA000_0002,  1);
      add(0, 0, 32'h0,          1, 32'hA000_0003,  1, 32'h0000_0010, 32'hC,          32'hA000_0003,  1);
      add(0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_0010, 32'hC,          32'h0,          0);
      add(0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_0010, 32'hC,          32'h0,          0);
      add(0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_0010, 32'hC,          32'h0,          0);
      add(0, 0, 32'h0,          1, 32'hA000_0004,  1, 32'h0000_0014, 32'h10,         32'hA000_0004,  1);
      add(0, 0, 32'h0,          1, 32'hA000_0005,  1, 32'h0000_0018, 32'h14,         32'hA000_0005,  1);
      add(0, 0, 32'h0,          1, 32'hA000_0006,  1, 32'h0000_001C, 32'h18,         32'hA000_0006,  1);
      add(0, 0, 32'h0,          1, 32'hA000_0007,  1, 32'h0000_0020, 32'h1C,         32'hA000_0007,  1);
      add(1, 0, 32'h0,          1, 32'hA000_0008,  0, 32'h0000_0024, 32'h1C,         32'hA000_0007,  1);
      add(1, 0, 32'h0,          0, 32'h0,          0, 32'h0000_0024, 32'h1C,         32'hA000_0007,  1);
      add(1, 0, 32'h0,          0, 32'h0,          0, 32'h0000_0024, 32'h1C,         32'hA000_0007,  1);
      add(1, 0, 32'h0,          0, 32'h0,          0, 32'h0000_0024, 32'h1C,         32'hA000_0007,  1);
      add(0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_0024, 32'h20,         32'hA000_0008,  1);
      add(0, 0, 32'h0,          1, 32'hA000_0009,  1, 32'h0000_0028, 32'h24,         32'hA000_0009,  1);
      add(0, 0, 32'h0,          1, 32'hA000_000A,  1, 32'h0000_002C, 32'h28,         32'hA000_000A,  1);
      add(0, 0, 32'h0,          1, 32'hA000_000B,  1, 32'h0000_0030, 32'h2C,         32'hA000_000B,  1);
      add(0, 1, 32'h100,        0, 32'h0,          1, 32'h0000_0030, 32'h2C,         32'h0,          0);
      add(0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_0030, 32'h2C,         32'h0,          0);
      add(0, 0, 32'h0,          1, 32'hA000_000C,  1, 32'h0000_0100, 32'h2C,         32'h0,          0);
      add(0, 0, 32'h0,          1, 32'hA000_000D,  1, 32'h0000_0104, 32'h100,        32'hA000_000D,  1);
      add(0, 1, 32'h203,        1, 32'hA000_000E,  1, 32'h0000_0200, 32'h100,        32'h0,          0);
      add(0, 1, 32'hFFFF_FFFC,  1, 32'hA000_000F,  1, 32'hFFFF_FFFC, 32'h100,        32'h0,          0);
      add(0, 0, 32'h0,          1, 32'hA000_0010,  1, 32'h0000_0000, 32'hFFFF_FFFC,  32'hA000_0010,  1);
      add(1, 1, 32'h300,        1, 32'hA000_0011,  1, 32'h0000_0300, 32'hFFFF_FFFC,  32'hA000_0010,  1);
      add(1, 0, 32'h0,          1, 32'hA000_0012,  0, 32'h0000_0304, 32'hFFFF_FFFC,  32'hA000_0010,  1);
      add(0, 1, 32'h400,        0, 32'h0,          1, 32'h0000_0400, 32'hFFFF_FFFC,  32'h0,          0);
      add(0, 0, 32'h0,          1, 32'hA000_0013,  1, 32'h0000_0404, 32'h400,        32'hA000_0013,  1);

      do_reset("reset0");
      for (int i = 0; i < vq.size(); i++) begin
         drive(vq[i].stall, vq[i].br, vq[i].tgt, vq[i].ack, vq[i].rdata);
         @(posedge clk);
         #1;
         chk_all($sformatf("vec%0d", i), vq[i].e_req, vq[i].e_addr, vq[i].e_pc,
                 vq[i].e_inst, vq[i].e_valid);
         @(negedge clk);
      end

      // ---------------- Reset while a request to 0x40 is open ----------------
      do_reset("reset1");
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, 1'b0, 32'd0, 1'b1, 32'hB000_0000 + 32'(i));
         @(posedge clk);
         @(negedge clk);
      end
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      chk_all("pre_rst", 1'b1, 32'h40, 32'h3C, 32'hB000_000F, 1'b1);
      rst = 1'b1;
      #1;
      chk_all("mid_rst", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      drive(1'b0, 1'b0, 32'd0, 1'b1, 32'hDEAD_BEEF);
      @(posedge clk);
      #1;
      chk_all("late_ack", 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk_all("restart", 1'b1, 32'h0, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      drive(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_1234);
      @(posedge clk);
      #1;
      chk_all("restart_ack", 1'b1, 32'h4, 32'h0, 32'h0000_1234, 1'b1);

      // ---------------- Randomized run against the model ----------------
      do_reset("reset2");
      for (int c = 0; c < 3000; c++) begin
         s = ($urandom_range(0, 3) == 0);
         b = ($urandom_range(0, 9) == 0);
         t = $urandom;
         if ($urandom_range(0, 5) == 0) t = 32'hFFFF_FFF0 | ($urandom & 32'hF);
         a = bus.imem_req_o && ($urandom_range(0, 1) == 1);
         d = $urandom;
         drive(s, b, t, a, d);
         @(posedge clk);
         model_step(s, b, t, a, d);
         #1;
         chk_all($sformatf("rnd%0d", c), (m_buf.size() == 0), m_pc, m_opc, m_oinst, m_ovalid);
         @(negedge clk);
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
